// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_pkg: denominations, one-hot codes and FSM states for change     |
// | dispensing.                                    Revision: 1.0         |
// +----------------------------------------------------------------------+
package vend_pkg;

  localparam int N_DENOM = 5;

  localparam logic [7:0] c_val50 = 8'd50;
  localparam logic [7:0] c_val20 = 8'd20;
  localparam logic [7:0] c_val10 = 8'd10;
  localparam logic [7:0] c_val5  = 8'd5;
  localparam logic [7:0] c_val1  = 8'd1;

  localparam logic [4:0] c_oh50 = 5'b10000;
  localparam logic [4:0] c_oh20 = 5'b01000;
  localparam logic [4:0] c_oh10 = 5'b00100;
  localparam logic [4:0] c_oh5  = 5'b00010;
  localparam logic [4:0] c_oh1  = 5'b00001;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_SELECT = 5'b00010,
    S_ISSUE  = 5'b00100,
    S_DONE   = 5'b01000,
    S_FAULT  = 5'b10000
  } state_t;

  function automatic logic [7:0] denom_value(input logic [4:0] oh);
    logic [7:0] v;
    case (oh)
      c_oh50:  v = c_val50;
      c_oh20:  v = c_val20;
      c_oh10:  v = c_val10;
      c_oh5:   v = c_val5;
      c_oh1:   v = c_val1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] index_value(input int idx);
    logic [7:0] v;
    case (idx)
      4:       v = c_val50;
      3:       v = c_val20;
      2:       v = c_val10;
      1:       v = c_val5;
      default: v = c_val1;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/denom_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | denom_select: greedy pick of the largest stocked denomination that   |
// | still fits the amount owed.                    Revision: 1.0         |
// +----------------------------------------------------------------------+
module denom_select import vend_pkg::*; (
  input  logic [7:0]         i_remaining,
  input  logic [N_DENOM-1:0] i_nonzero,
  output logic [N_DENOM-1:0] o_pick,
  output logic               o_found
);

  always_comb begin
    o_pick  = '0;
    o_found = 1'b0;
    for (int i = N_DENOM - 1; i >= 0; i--) begin
      if (!o_found && i_nonzero[i] && (index_value(i) <= i_remaining)) begin
        o_pick[i] = 1'b1;
        o_found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | change_dispense_ctrl: pays out change one item at a time with        |
// | inventory tracking, refill and ack timeout.    Revision: 1.0         |
// +----------------------------------------------------------------------+
module change_dispense_ctrl import vend_pkg::*; #(
  parameter int CNT_W       = 6,
  parameter int INIT_CNT    = 10,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     req_valid,
  input  logic [7:0]               req_amount,
  output logic                     req_ready,
  output logic                     disp_valid,
  output logic [4:0]               disp_denom,
  input  logic                     disp_ack,
  input  logic                     refill_en,
  input  logic [4:0]               refill_denom,
  input  logic [CNT_W-1:0]         refill_cnt,
  input  logic                     clear_fault,
  output logic [7:0]               remaining,
  output logic                     done,
  output logic [7:0]               shortfall,
  output logic                     fault,
  output logic [5*CNT_W-1:0]       inv_cnt
);

  localparam logic [7:0]       c_ack_timeout = 8'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] c_init_cnt    = CNT_W'(INIT_CNT);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt [N_DENOM];
  logic [CNT_W-1:0]   w_refill_val [N_DENOM];
  logic [7:0]         r_remaining;
  logic [7:0]         r_shortfall;
  logic [7:0]         r_timer;
  logic [4:0]         r_denom;
  logic [N_DENOM-1:0] w_nonzero;
  logic [N_DENOM-1:0] w_pick;
  logic               w_found;
  logic               w_refill_ok;
  logic [7:0]         w_issue_val;

  denom_select u_denom_select (
    .i_remaining (r_remaining),
    .i_nonzero   (w_nonzero),
    .o_pick      (w_pick),
    .o_found     (w_found)
  );

  assign w_issue_val = denom_value(r_denom);
  assign w_refill_ok = refill_en && (refill_denom != 5'd0) &&
                       ((refill_denom & (refill_denom - 5'd1)) == 5'd0);

  // Saturating refill sums, one extra bit to catch the carry.
  always_comb begin
    logic [CNT_W:0] sum;
    sum = '0;
    for (int i = 0; i < N_DENOM; i++) begin
      w_nonzero[i]    = (r_cnt[i] != '0);
      sum             = {1'b0, r_cnt[i]} + {1'b0, refill_cnt};
      w_refill_val[i] = sum[CNT_W] ? c_cnt_max : sum[CNT_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    disp_valid  = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (req_amount == 8'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: w_state_nxt = w_found ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        disp_valid = 1'b1;
        if (disp_ack)
          w_state_nxt = (r_remaining == w_issue_val) ? S_DONE : S_SELECT;
        else if (r_timer == c_ack_timeout)
          w_state_nxt = S_FAULT;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (clear_fault) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
      r_shortfall <= 8'd0;
      r_timer     <= 8'd0;
      r_denom     <= 5'd0;
      for (int i = 0; i < N_DENOM; i++) r_cnt[i] <= c_init_cnt;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_remaining <= req_amount;
          r_shortfall <= 8'd0;
        end
        S_SELECT: if (w_found) r_denom <= w_pick;
        else begin
          r_shortfall <= r_remaining;
          r_remaining <= 8'd0;
        end
        S_ISSUE: begin
          if (disp_ack) begin
            r_remaining <= r_remaining - w_issue_val;
            r_timer     <= 8'd0;
          end else if (r_timer == c_ack_timeout) r_timer <= 8'd0;
          else r_timer <= r_timer + 8'd1;
        end
        S_FAULT: if (clear_fault) begin
          r_shortfall <= r_remaining;
          r_remaining <= 8'd0;
        end
        default: ;
      endcase
      // SELECT only picks stocked denominations, so the decrement cannot wrap.
      for (int i = 0; i < N_DENOM; i++) begin
        if ((r_state == S_IDLE) && w_refill_ok && refill_denom[i])
          r_cnt[i] <= w_refill_val[i];
        else if ((r_state == S_ISSUE) && disp_ack && r_denom[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    inv_cnt = '0;
    for (int i = 0; i < N_DENOM; i++) inv_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end

  assign disp_denom = r_denom;
  assign remaining  = r_remaining;
  assign shortfall  = r_shortfall;

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_change_dispense_ctrl: directed bench with a greedy payout model.  |
// |                                                Revision: 1.0         |
// +----------------------------------------------------------------------+
module tb_change_dispense_ctrl;

  localparam int CNT_W       = 6;
  localparam int INIT_CNT    = 10;
  localparam int ACK_TIMEOUT = 255;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b1;
  logic               req_valid = 1'b0;
  logic [7:0]         req_amount = 8'd0;
  logic               req_ready;
  logic               disp_valid;
  logic [4:0]         disp_denom;
  logic               disp_ack = 1'b0;
  logic               refill_en = 1'b0;
  logic [4:0]         refill_denom = 5'd0;
  logic [CNT_W-1:0]   refill_cnt = '0;
  logic               clear_fault = 1'b0;
  logic [7:0]         remaining;
  logic               done;
  logic [7:0]         shortfall;
  logic               fault;
  logic [5*CNT_W-1:0] inv_cnt;

  always #5 sys_clk = ~sys_clk;

  change_dispense_ctrl #(
    .CNT_W       (CNT_W),
    .INIT_CNT    (INIT_CNT),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .disp_valid   (disp_valid),
    .disp_denom   (disp_denom),
    .disp_ack     (disp_ack),
    .refill_en    (refill_en),
    .refill_denom (refill_denom),
    .refill_cnt   (refill_cnt),
    .clear_fault  (clear_fault),
    .remaining    (remaining),
    .done         (done),
    .shortfall    (shortfall),
    .fault        (fault),
    .inv_cnt      (inv_cnt)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         den_val[5] = '{1, 5, 10, 20, 50};
  int         inv_m[5];
  int         model_rem = 0;
  logic [4:0] exp_denom = 5'd0;
  bit         mon_en = 1'b0;
  int         n_issued = 0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5*CNT_W-1:0] model_pack();
    logic [5*CNT_W-1:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) p[i*CNT_W +: CNT_W] = CNT_W'(inv_m[i]);
    return p;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) inv_m[i] = INIT_CNT;
    model_rem = 0;
  endtask

  // Compare process: in IDLE the inventory must match the model, while issuing
  // the command must match the expected greedy item and amount still owed.
  always @(negedge sys_clk) begin
    if (disp_valid && !prev_valid) n_issued++;
    prev_valid = disp_valid;
    if (mon_en) begin
      if (req_ready) begin
        check("idle_inv", inv_cnt, model_pack());
        check("idle_remaining", remaining, 0);
        check("idle_disp_valid", disp_valid, 0);
      end
      if (disp_valid) begin
        check("issue_denom", disp_denom, exp_denom);
        check("issue_remaining", remaining, model_rem);
        check("issue_ready", req_ready, 0);
        check("issue_done", done, 0);
      end
    end
  end

  task automatic do_req(input int amt, input bit refill_mid);
    int plan[$];
    int inv_c[5];
    int rem, pick, short_exp, waited, issued0;
    inv_c = inv_m;
    rem   = amt;
    pick  = 0;
    while (rem > 0 && pick >= 0) begin
      pick = -1;
      for (int i = 4; i >= 0; i--)
        if (pick < 0 && inv_c[i] > 0 && den_val[i] <= rem) pick = i;
      if (pick >= 0) begin
        plan.push_back(pick);
        inv_c[pick]--;
        rem -= den_val[pick];
      end
    end
    short_exp = rem;
    issued0   = n_issued;
    check("req_ready", req_ready, 1);
    model_rem  = amt;
    req_valid  = 1'b1;
    req_amount = amt[7:0];
    tick();
    req_valid = 1'b0;
    foreach (plan[k]) begin
      exp_denom = 5'(1 << plan[k]);
      waited = 0;
      while (!disp_valid && waited < 8) begin
        tick();
        waited++;
      end
      check("issue_latency", waited, 1);
      if (refill_mid && k == 0) begin
        refill_en = 1'b1; refill_denom = 5'b00001; refill_cnt = CNT_W'(5);
        tick();
        refill_en = 1'b0;
      end
      repeat (k % 3) tick();
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
      inv_m[plan[k]]--;
      model_rem -= den_val[plan[k]];
    end
    waited = 0;
    while (!done && waited < 4) begin
      tick();
      waited++;
    end
    check("done_seen", done, 1);
    check("shortfall", shortfall, short_exp);
    check("items_issued", n_issued - issued0, plan.size());
    tick();
    check("done_one_cycle", done, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    int waited;
    model_reset();
    tick();
    tick();
    sys_rst_n = 1'b0;
    check("rst_inv", inv_cnt, {5{6'd10}});
    check("rst_ready", req_ready, 1);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_denom", disp_denom, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_remaining", remaining, 0);
    check("rst_shortfall", shortfall, 0);
    mon_en = 1'b1;

    // 76 = 50+20+5+1
    do_req(76, 1'b0);
    check("t1_inv_lit", inv_cnt, {6'd9, 6'd9, 6'd10, 6'd9, 6'd9});

    // Empty the 50s, then 60 must come out as three 20s.
    do_req(200, 1'b0);
    do_req(250, 1'b0);
    check("c50_empty_lit", inv_cnt[4*CNT_W +: CNT_W], 0);
    do_req(60, 1'b0);
    check("t2_c20_lit", inv_cnt[3*CNT_W +: CNT_W], 6);
    check("t2_short_lit", shortfall, 0);

    // Empty the 5s and bring the 1s down to 2, then ask for 3.
    for (int j = 0; j < 9; j++) do_req(5, 1'b0);
    do_req(4, 1'b0);
    do_req(3, 1'b0);
    check("c1_two_lit", inv_cnt[0 +: CNT_W], 2);
    do_req(3, 1'b0);
    check("t3_short_lit", shortfall, 1);
    check("t3_c1_lit", inv_cnt[0 +: CNT_W], 0);
    check("t3_c5_lit", inv_cnt[CNT_W +: CNT_W], 0);

    do_req(0, 1'b0);
    check("t4_short_lit", shortfall, 0);

    // Ack timeout.
    model_rem  = 20;
    exp_denom  = 5'b01000;
    req_valid  = 1'b1;
    req_amount = 8'd20;
    tick();
    req_valid = 1'b0;
    tick();
    check("t5_valid", disp_valid, 1);
    waited = 0;
    while (!fault && waited < ACK_TIMEOUT + 10) begin
      tick();
      waited++;
    end
    check("t5_fault", fault, 1);
    check("t5_timeout_min", waited >= ACK_TIMEOUT, 1);
    check("t5_timeout_max", waited <= ACK_TIMEOUT + 2, 1);
    check("t5_valid_low", disp_valid, 0);
    check("t5_inv", inv_cnt, model_pack());
    req_valid  = 1'b1;
    req_amount = 8'd5;
    tick();
    req_valid = 1'b0;
    check("t5_ignores_req", fault, 1);
    check("t5_not_ready", req_ready, 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("t5_fault_clr", fault, 0);
    check("t5_ready", req_ready, 1);
    check("t5_short_lit", shortfall, 20);

    // Saturating refill and a non-one-hot refill.
    refill_en = 1'b1; refill_denom = 5'b00100; refill_cnt = CNT_W'(60);
    tick();
    inv_m[2] = 63;
    check("t6_sat_lit", inv_cnt[2*CNT_W +: CNT_W], 63);
    refill_denom = 5'b00011; refill_cnt = CNT_W'(5);
    tick();
    refill_en = 1'b0;
    check("t6_bad_refill", inv_cnt, model_pack());

    do_req(10, 1'b1);
    check("t6_mid_refill_c1_lit", inv_cnt[0 +: CNT_W], 0);
    check("t6_c10_lit", inv_cnt[2*CNT_W +: CNT_W], 62);

    // Reset during ISSUE.
    model_rem  = 10;
    exp_denom  = 5'b00100;
    req_valid  = 1'b1;
    req_amount = 8'd10;
    tick();
    req_valid = 1'b0;
    tick();
    check("t6_in_issue", disp_valid, 1);
    mon_en    = 1'b0;
    sys_rst_n = 1'b1;
    tick();
    check("t6_rst_valid", disp_valid, 0);
    sys_rst_n = 1'b0;
    check("t6_rst_inv", inv_cnt, {5{6'd10}});
    check("t6_rst_remaining", remaining, 0);
    model_reset();
    mon_en = 1'b1;
    do_req(76, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
